cpu_bus_responder: RTL and testbench

CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

---
 rtl/cpu_bus_responder.sv | 169 ++++++++++++++++
 tb/tb_cpu_bus_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_responder.sv
// ---------------------------------------------------------------------------
// cpu_bus_responder
//   Slave-side bus responder for an 8-bit CPU with a 16-bit address bus.
//   Each request is keyed by {address, write}. A request is answered
//   WAIT_STATES+1 cycles after it is accepted. The answer stays valid while
//   the CPU holds the same key. If the key changes, the old request is
//   abandoned and the new key starts a fresh request.
//
//   Memory map:
//     $0000-$1FFF  2 KiB RAM, indexed by address[10:0] (mirrored four times)
//     $FFFA-$FFFF  NMI / RESET / IRQ vectors, little-endian, read-only
//     others       unmapped; reads return the open-bus latch
//
// Ports:
//   clock_i          sole clock, rising edge
//   reset_n_i        asynchronous active-low reset
//   address_i        CPU address
//   address_valid_i  CPU is driving a valid address
//   data_i           CPU write data
//   write_valid_i    current access is a write
//   data_o           read data, or the echoed write data
//   data_valid_o     data_o belongs to the current address_i/write_valid_i
// ---------------------------------------------------------------------------
module cpu_bus_responder #(
    parameter int unsigned WAIT_STATES  = 2,
    parameter logic [15:0] RESET_VECTOR = 16'h8000,
    parameter logic [15:0] NMI_VECTOR   = 16'h8000,
    parameter logic [15:0] IRQ_VECTOR   = 16'h8000
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic [15:0] address_i,
    input  logic        address_valid_i,
    input  logic [7:0]  data_i,
    input  logic        write_valid_i,
    output logic [7:0]  data_o,
    output logic        data_valid_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_count;
    logic [3:0]  w_count_nxt;
    logic [16:0] r_key;
    logic [16:0] w_key;
    logic        w_key_match;
    logic        w_accept;
    logic        w_enter_done;
    logic [15:0] w_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_data;
    logic [7:0]  r_open_bus;
    logic [7:0]  w_resp;
    logic [7:0]  r_ram [0:2047];

    // RAM occupies $0000-$1FFF: only the top three address bits matter.
    function automatic logic is_ram(input logic [2:0] top);
        return (top == 3'b000);
    endfunction

    // Vector window is $FFFA-$FFFF; $FFF8/$FFF9 are unmapped.
    function automatic logic is_vector(input logic [15:1] a);
        return (a[15:3] == 13'h1FFF) && (a[2:1] != 2'b00);
    endfunction

    // Little-endian vector byte for address bits [2:0].
    function automatic logic [7:0] vector_byte(input logic [2:0] sel);
        logic [7:0] v;
        case (sel)
            3'd2:    v = NMI_VECTOR[7:0];
            3'd3:    v = NMI_VECTOR[15:8];
            3'd4:    v = RESET_VECTOR[7:0];
            3'd5:    v = RESET_VECTOR[15:8];
            3'd6:    v = IRQ_VECTOR[7:0];
            3'd7:    v = IRQ_VECTOR[15:8];
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    assign w_key       = {address_i, write_valid_i};
    assign w_key_match = (w_key == r_key);
    assign w_addr      = r_key[16:1];

    // Next-state logic. A new request is accepted from IDLE, or when the key changes mid-access.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_accept    = 1'b0;
        if (!address_valid_i) begin
            w_state_nxt = ST_IDLE;
        end else if ((r_state == ST_IDLE) || !w_key_match) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_WAIT;
            w_count_nxt = LP_WAIT;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (r_count != 4'd0) begin
                        w_count_nxt = r_count - 4'd1;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: w_state_nxt = ST_DONE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_enter_done = (r_state == ST_WAIT) && (w_state_nxt == ST_DONE);

    // Response byte for the latched key. RAM was already written at acceptance, so a read after a write returns the new value.
    always_comb begin
        w_resp = r_open_bus;
        if (r_key[0]) begin
            w_resp = r_wdata;
        end else if (is_ram(w_addr[15:13])) begin
            w_resp = r_ram[w_addr[10:0]];
        end else if (is_vector(w_addr[15:1])) begin
            w_resp = vector_byte(w_addr[2:0]);
        end else begin
            w_resp = r_open_bus;
        end
    end

    // Control state, the request key and the response/open-bus registers.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= ST_IDLE;
            r_count    <= 4'd0;
            r_key      <= 17'd0;
            r_wdata    <= 8'h00;
            r_data     <= 8'h00;
            r_open_bus <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_accept) begin
                r_key   <= w_key;
                r_wdata <= data_i;
            end
            if (w_enter_done) begin
                r_data     <= w_resp;
                r_open_bus <= w_resp;
            end
        end
    end

    // RAM storage is not reset. Each accepted write commits once, at the acceptance edge.
    always_ff @(posedge clock_i) begin
        if (reset_n_i && w_accept && write_valid_i && is_ram(address_i[15:13])) begin
            r_ram[address_i[10:0]] <= data_i;
        end
    end

    // data_valid_o is gated combinationally so that a key change or a dropped address_valid_i removes it in the same cycle.
    assign data_o       = r_data;
    assign data_valid_o = (r_state == ST_DONE) && address_valid_i && w_key_match;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_cpu_bus_responder
//   Directed self-checking bench. It drives two instances with the same
//   stimulus: one with default parameters and one with WAIT_STATES=0.
//   sel0 chooses which instance is observed. An expected response byte is
//   queued when a request is driven. It is popped and compared when
//   data_valid_o rises, and the latency is checked at the same time.
// ---------------------------------------------------------------------------
module tb_cpu_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr;
    logic        av;
    logic [7:0]  din;
    logic        wv;
    logic [7:0]  do_a;
    logic        dv_a;
    logic [7:0]  do_b;
    logic        dv_b;
    logic        sel0;
    logic [7:0]  obs_d;
    logic        obs_v;

    int          passes = 0;
    int          total  = 0;
    logic [7:0]  sb [$];

    always #5 clk = ~clk;

    assign obs_d = sel0 ? do_b : do_a;
    assign obs_v = sel0 ? dv_b : dv_a;

    cpu_bus_responder dut (
        .clock_i        (clk),
        .reset_n_i      (rst_n),
        .address_i      (addr),
        .address_valid_i(av),
        .data_i         (din),
        .write_valid_i  (wv),
        .data_o         (do_a),
        .data_valid_o   (dv_a)
    );

    cpu_bus_responder #(.WAIT_STATES(0)) dut0 (
        .clock_i        (clk),
        .reset_n_i      (rst_n),
        .address_i      (addr),
        .address_valid_i(av),
        .data_i         (din),
        .write_valid_i  (wv),
        .data_o         (do_b),
        .data_valid_o   (dv_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge. Drives one request and waits for its response.
    task automatic access(input logic [15:0] a, input logic wr, input logic [7:0] d,
                          input logic [7:0] e, input int lat, input string tag);
        int         k;
        logic [7:0] exp_d;
        addr = a;
        wv   = wr;
        din  = d;
        av   = 1'b1;
        sb.push_back(e);
        #1;
        check({tag, "_drop"}, 32'(obs_v), 32'd0);
        k = 0;
        while (k < 20 && !obs_v) begin
            @(negedge clk);
            k++;
        end
        if (obs_v) begin
            check({tag, "_lat"}, 32'(k - 1), 32'(lat));
            exp_d = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            check({tag, "_data"}, 32'(obs_d), 32'(exp_d));
        end else begin
            check({tag, "_timeout"}, 32'(obs_v), 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    task automatic idle(input string tag);
        av = 1'b0;
        #1;
        check({tag, "_dv"}, 32'(obs_v), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        addr  = 16'h0000;
        av    = 1'b0;
        din   = 8'h00;
        wv    = 1'b0;
        sel0  = 1'b0;
        #2;
        check("rst_dv_a", 32'(dv_a), 32'd0);
        check("rst_do_a", 32'(do_a), 32'd0);
        check("rst_dv_b", 32'(dv_b), 32'd0);
        check("rst_do_b", 32'(do_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset-vector bytes, little-endian
        access(16'hFFFC, 1'b0, 8'h00, 8'h00, 3, "rd_fffc");
        access(16'hFFFD, 1'b0, 8'h00, 8'h80, 3, "rd_fffd");

        // RAM mirror
        access(16'h0123, 1'b1, 8'h5A, 8'h5A, 3, "wr_0123");
        access(16'h0923, 1'b0, 8'h00, 8'h5A, 3, "rd_0923");
        access(16'h1923, 1'b0, 8'h00, 8'h5A, 3, "rd_1923");

        // Write held in DONE while data_i changes: no re-commit
        access(16'h0010, 1'b1, 8'h33, 8'h33, 3, "wr_0010");
        din = 8'h77;
        repeat (10) @(negedge clk);
        check("hold_dv", 32'(obs_v), 32'd1);
        check("hold_data", 32'(obs_d), 32'h33);
        access(16'h0010, 1'b0, 8'h77, 8'h33, 3, "rd_0010");
        access(16'h4000, 1'b0, 8'h00, 8'h33, 3, "rd_openbus");

        // Vector writes are ignored, but the open bus follows the echo
        access(16'hFFFC, 1'b1, 8'hAA, 8'hAA, 3, "wr_fffc");
        access(16'hFFFC, 1'b0, 8'h00, 8'h00, 3, "rd_fffc2");
        access(16'h2000, 1'b0, 8'h00, 8'h00, 3, "rd_openbus2");

        // Read right after a write to the same address
        access(16'h0200, 1'b1, 8'h42, 8'h42, 3, "wr_0200");
        access(16'h0200, 1'b0, 8'h00, 8'h42, 3, "rd_0200");
        idle("idle1");

        // Address change mid-WAIT restarts the count; the old request gets no response
        addr = 16'h0123;
        wv   = 1'b0;
        av   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_dv", 32'(obs_v), 32'd0);
        access(16'hFFFF, 1'b0, 8'h00, 8'h80, 3, "rd_ffff_restart");

        // Reset mid-WAIT of a write. The commit made at acceptance survives.
        addr = 16'h0300;
        wv   = 1'b1;
        din  = 8'h99;
        av   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_dv", 32'(dv_a), 32'd0);
        check("midrst_do", 32'(do_a), 32'd0);
        av = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        access(16'h0300, 1'b0, 8'h00, 8'h99, 3, "rd_0300_postrst");
        access(16'h0123, 1'b0, 8'h00, 8'h5A, 3, "rd_0123_ramkept");

        // WAIT_STATES=0 instance
        sel0 = 1'b1;
        idle("idle_ws0");
        access(16'hFFFC, 1'b0, 8'h00, 8'h00, 1, "ws0_rd_fffc");
        access(16'h0923, 1'b0, 8'h00, 8'h5A, 1, "ws0_rd_0923");
        idle("idle_end");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
